mem_io_bridge: RTL
==================

Name: mem_io_bridge

Overview:
- Sequential successor to the combinational memory/IO steering stage; sits between the ALU/controller and Data-Memory plus peripheral channels.
- Decodes memory vs IO space, generates byte-lane write enables, and performs sign/zero extension for byte/half/word loads.
- Selects one of IO_CH peripheral channels and inserts programmable IO wait states.
- Reports completion with a done pulse and stalls the core via busy.

Parameters:
- ADDR_W, 32, address width
- IO_BASE, 32'hFFFF_FC00, first IO address; addr_in >= IO_BASE is IO space
- IO_CH, 4, number of IO channels (power of 2, >=2)
- IO_W, 24, data width of each IO channel (<=32)
- IO_SEL_LSB, 4, lowest addr bit of the channel index field
- IO_WAIT, 2, cycles an IO strobe is held (>=1)

Ports:
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request, sampled in IDLE only
- rd  in  1  load request qualifier
- wr  in  1  store request qualifier
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- uns  in  1  1 = zero-extend load, 0 = sign-extend
- addr_in  in  ADDR_W  byte address from ALU
- r_rdata  in  32  store data from register file
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; access aborted
- r_wdata  out  32  load result, registered, held until next done
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_we  out  4  byte write enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  synchronous Data-Memory read data (1-cycle latency)
- io_cs  out  IO_CH  one-hot channel select
- io_rd  out  1  IO read strobe
- io_wr  out  1  IO write strobe
- io_wdata  out  IO_W  r_rdata[IO_W-1:0]
- io_rdata  in  IO_CH*IO_W  channel c occupies bits [c*IO_W +: IO_W]

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0. A transfer in flight is abandoned: strobes and enables drop without waiting for a clock edge, and no done is issued.
- States: IDLE, MEM, MEM_RD, IO, RESP.
- Acceptance: req=1 in IDLE latches addr, size, uns, rd, wr and r_rdata (cycle N). req is ignored in all other states.
- Error check at acceptance sends the FSM directly to RESP with err=1, r_wdata=0 and no memory/IO strobe. Error conditions:
  - rd==wr
  - size==11
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - IO channel index addr[IO_SEL_LSB +: log2(IO_CH)] >= IO_CH; cannot occur with power-of-2 IO_CH, kept for generality
- Memory store:
  - MEM in cycle N+1 drives mem_we for exactly one cycle:
    - byte: 1<<addr[1:0]
    - half: 0011 if addr[1]=0, else 1100
    - word: 1111
  - mem_wdata: byte replicated x4, half replicated x2, word as-is.
  - RESP in N+2.
- Memory load:
  - MEM (N+1) presents mem_addr with mem_we=0.
  - MEM_RD (N+2) captures mem_rdata, extracts the lane selected by addr[1:0] and size, and extends per uns.
  - RESP (N+3).
- IO access:
  - IO state for exactly IO_WAIT cycles (N+1..N+IO_WAIT).
  - io_cs, io_rd/io_wr and io_wdata are held constant throughout.
  - Read data is sampled on the last IO cycle from the selected slice and zero-extended to 32; size and uns are ignored for IO.
  - RESP at N+IO_WAIT+1.
- RESP: done=1 for one cycle, busy still 1; next state IDLE. A new req is accepted at the earliest in the following cycle.
- Outside MEM/IO states, mem_we=0, io_cs=0, io_rd=0 and io_wr=0; mem_addr and io_wdata are don't-care but driven (no Z).
- Loads leave r_wdata unchanged on stores, except an error, which clears it to 0.

Test Plan:
- Reset is released. Load word from 0x10 with mem_rdata=0x8899AABB. Required: done at N+3, r_wdata=0x8899AABB, err=0, mem_we stays 0000.
- lb from 0x13 (uns=0) with mem_rdata=0x80112233 -> r_wdata=0xFFFFFF80. Same access with uns=1 -> 0x00000080.
- sh of r_rdata=0x1234ABCD to 0x22. Required: at N+1, mem_we=1100, mem_wdata=0xABCDABCD, mem_addr=0x20; done at N+2.
- IO read at IO_BASE+0x20 (channel 2, IO_WAIT=2) with io_rdata slice 2 = 0xC0FFEE. Required: io_cs=0100 and io_rd=1 for N+1..N+2, done at N+3, r_wdata=0x00C0FFEE.
- lw at 0x06 -> done at N+1 with err=1, r_wdata=0, and no strobe asserted. rd=wr=1 gives the identical response.
- Assert rst_n low during an IO write's first wait cycle. Required: io_wr, io_cs and busy go 0 immediately; no done appears after release; the next req is accepted normally.

Source files
------------

// File: rtl/mem_io_bridge.sv
// Memory / IO access bridge: decodes memory vs IO space, drives byte-lane
// stores, extends loads, and sequences IO channel strobes with wait states.
module mem_io_bridge #(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  IO_BASE    = ADDR_W'(32'hFFFF_FC00),
  parameter int unsigned        IO_CH      = 4,
  parameter int unsigned        IO_W       = 24,
  parameter int unsigned        IO_SEL_LSB = 4,
  parameter int unsigned        IO_WAIT    = 2
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   rd,
  input  logic                   wr,
  input  logic [1:0]             size,
  input  logic                   uns,
  input  logic [ADDR_W-1:0]      addr_in,
  input  logic [31:0]            r_rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            r_wdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [3:0]             mem_we,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic [IO_CH-1:0]       io_cs,
  output logic                   io_rd,
  output logic                   io_wr,
  output logic [IO_W-1:0]        io_wdata,
  input  logic [IO_CH*IO_W-1:0]  io_rdata
);

  localparam int unsigned SEL_W  = $clog2(IO_CH);
  localparam int unsigned WCNT_W = (IO_WAIT > 1) ? $clog2(IO_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_MEM_RD,
    S_IO,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [1:0]        r_lane;
  logic [1:0]        r_size;
  logic              r_uns;
  logic              r_rd;
  logic [SEL_W-1:0]  r_ch;
  logic [WCNT_W-1:0] r_wcnt;

  logic              w_is_io;
  logic [SEL_W-1:0]  w_ch;
  logic [IO_CH-1:0]  w_cs;
  logic              w_err;
  logic [3:0]        w_we;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld;
  logic [IO_W-1:0]   w_io_slice;

  assign w_is_io    = (addr_in >= IO_BASE);
  assign w_ch       = addr_in[IO_SEL_LSB +: SEL_W];
  assign w_cs       = IO_CH'(1) << w_ch;
  assign w_io_slice = io_rdata[int'(r_ch) * IO_W +: IO_W];

  always_comb begin
    w_err = (rd == wr) || (size == 2'b11);
    if (size == 2'b01 && addr_in[0])
      w_err = 1'b1;
    if (size == 2'b10 && addr_in[1:0] != 2'b00)
      w_err = 1'b1;
    if (w_is_io && int'(w_ch) >= int'(IO_CH))
      w_err = 1'b1;
  end

  always_comb begin
    w_we    = 4'b1111;
    w_wdata = r_rdata;
    case (size)
      2'b00: begin
        w_we    = 4'b0001 << addr_in[1:0];
        w_wdata = {4{r_rdata[7:0]}};
      end
      2'b01: begin
        w_we    = addr_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_rdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction uses the offset/size latched at acceptance, since
  // mem_rdata only arrives two cycles later.
  always_comb begin
    w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   w_ld = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ld = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ld = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lane    <= '0;
      r_size    <= '0;
      r_uns     <= 1'b0;
      r_rd      <= 1'b0;
      r_ch      <= '0;
      r_wcnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      r_wdata   <= '0;
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
      io_cs     <= '0;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
      io_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_lane   <= addr_in[1:0];
            r_size   <= size;
            r_uns    <= uns;
            r_rd     <= rd;
            r_ch     <= w_ch;
            busy     <= 1'b1;
            mem_addr <= {addr_in[ADDR_W-1:2], 2'b00};
            if (w_err) begin
              r_state <= S_RESP;
              done    <= 1'b1;
              err     <= 1'b1;
              r_wdata <= '0;
            end else if (w_is_io) begin
              r_state  <= S_IO;
              io_cs    <= w_cs;
              io_rd    <= rd;
              io_wr    <= wr;
              io_wdata <= r_rdata[IO_W-1:0];
              r_wcnt   <= WCNT_W'(IO_WAIT - 1);
            end else begin
              r_state   <= S_MEM;
              mem_we    <= wr ? w_we : '0;
              mem_wdata <= w_wdata;
            end
          end
        end
        S_MEM: begin
          mem_we <= '0;
          if (r_rd) begin
            r_state <= S_MEM_RD;
          end else begin
            r_state <= S_RESP;
            done    <= 1'b1;
            err     <= 1'b0;
          end
        end
        S_MEM_RD: begin
          r_state <= S_RESP;
          r_wdata <= w_ld;
          done    <= 1'b1;
          err     <= 1'b0;
        end
        S_IO: begin
          if (r_wcnt == '0) begin
            r_state <= S_RESP;
            io_cs   <= '0;
            io_rd   <= 1'b0;
            io_wr   <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
            if (r_rd)
              r_wdata <= 32'(w_io_slice);
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
          mem_we  <= '0;
          io_cs   <= '0;
          io_rd   <= 1'b0;
          io_wr   <= 1'b0;
        end
      endcase
    end
  end

endmodule
